// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: drives the 8-bit PWM generator's period/duty, stepping duty toward a
// commanded target once per PWM period. Optional abort support: define PWM_RAMP_ABORT_EN.
module pwm_ramp_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] cmd_period,
   input  logic [W-1:0] cmd_duty,
   input  logic [W-1:0] cmd_step,
   output logic [W-1:0] period,
   output logic [W-1:0] duty_cycle,
   output logic         busy,
`ifdef PWM_RAMP_ABORT_EN
   input  logic         abort,
   output logic         aborted,
`endif
   output logic         done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;

   logic [W-1:0]   mcnt_r;
   logic [W:0]     nxt_ext_s;
   logic [W-1:0]   nxt_s;
   logic           bnd_s;

   logic [W-1:0]   period_r;
   logic [W-1:0]   duty_r;
   logic           busy_r;
   logic           done_r;
   logic [W-1:0]   tgt_period_r;
   logic [W-1:0]   tgt_duty_r;
   logic [W-1:0]   step_r;

   logic           accept_s;
   logic           upd_s;
   logic           fin_s;
   logic           abort_now_s;
   logic [W-1:0]   new_duty_s;

`ifdef PWM_RAMP_ABORT_EN
   logic           aborted_r;
   logic           abort_pend_r;
`endif

   // One ramp step, evaluated one bit wider so neither direction can wrap.
   function automatic logic [W-1:0] step_duty(input logic [W-1:0] cur,
                                              input logic [W-1:0] tgt,
                                              input logic [W-1:0] stp);
      logic [W:0] sum_v;
      logic [W:0] diff_v;
      logic [W-1:0] res_v;
      sum_v  = {1'b0, cur} + {1'b0, stp};
      diff_v = {1'b0, cur} - {1'b0, tgt};
      if (stp == {W{1'b0}}) begin
         res_v = tgt;
      end else if (cur < tgt) begin
         res_v = (sum_v >= {1'b0, tgt}) ? tgt : sum_v[W-1:0];
      end else if (cur > tgt) begin
         res_v = (diff_v <= {1'b0, stp}) ? tgt : (cur - stp);
      end else begin
         res_v = tgt;
      end
      return res_v;
   endfunction

   // Mirror of the generator counter; uses the period currently driven to the generator.
   always_comb begin
      nxt_ext_s = {1'b0, mcnt_r} + {{W{1'b0}}, 1'b1};
      if (nxt_ext_s >= {1'b0, period_r}) begin
         nxt_s = {W{1'b0}};
      end else begin
         nxt_s = nxt_ext_s[W-1:0];
      end
      bnd_s = (nxt_s == {W{1'b0}});
   end

   // Mirror counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt_r <= {W{1'b0}};
      end else begin
         mcnt_r <= nxt_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = RAMP;
            else          state_nxt_s = IDLE;
         end
         RAMP: begin
            if (fin_s) state_nxt_s = IDLE;
            else       state_nxt_s = RAMP;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs and per-boundary update decode.
   always_comb begin
      cmd_ready = 1'b0;
      upd_s     = 1'b0;
      case (state_r)
         IDLE:    cmd_ready = 1'b1;
         RAMP:    upd_s     = bnd_s;
         default: cmd_ready = 1'b0;
      endcase
      accept_s   = cmd_ready && cmd_valid;
      new_duty_s = step_duty(duty_r, tgt_duty_r, step_r);
`ifdef PWM_RAMP_ABORT_EN
      abort_now_s = abort_pend_r || abort;
`else
      abort_now_s = 1'b0;
`endif
      fin_s = upd_s && (abort_now_s || (new_duty_s == tgt_duty_r));
   end

   // Command capture and generator configuration; only boundary edges touch period/duty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_r     <= {W{1'b0}};
         duty_r       <= {W{1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         tgt_period_r <= {W{1'b0}};
         tgt_duty_r   <= {W{1'b0}};
         step_r       <= {W{1'b0}};
      end else begin
         done_r <= 1'b0;
         if (accept_s) begin
            tgt_period_r <= cmd_period;
            tgt_duty_r   <= cmd_duty;
            step_r       <= cmd_step;
            busy_r       <= 1'b1;
         end
         if (upd_s) begin
            if (abort_now_s) begin
               duty_r <= {W{1'b0}};
            end else begin
               period_r <= tgt_period_r;
               duty_r   <= new_duty_s;
               done_r   <= (new_duty_s == tgt_duty_r);
            end
            if (fin_s) busy_r <= 1'b0;
         end
      end
   end

`ifdef PWM_RAMP_ABORT_EN
   // Abort request is held until the next boundary consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort_pend_r <= 1'b0;
         aborted_r    <= 1'b0;
      end else begin
         aborted_r <= upd_s && abort_now_s;
         if (state_r == RAMP && !bnd_s) begin
            abort_pend_r <= abort_pend_r || abort;
         end else begin
            abort_pend_r <= 1'b0;
         end
      end
   end

   assign aborted = aborted_r;
`endif

   assign period     = period_r;
   assign duty_cycle = duty_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: a cycle model with an expected-duty queue
// filled at command accept and drained on each boundary; abort cases need PWM_RAMP_ABORT_EN.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_period;
   logic [7:0] cmd_duty;
   logic [7:0] cmd_step;
   logic [7:0] period;
   logic [7:0] duty_cycle;
   logic       busy;
   logic       done;
   logic       abort;
   logic       aborted;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // bench model of generator and controller
   int         gcnt;
   int         gper;
   int         tper;
   logic [7:0] mduty;
   bit         m_ramp;
   bit         m_done;
   bit         m_abd;
   bit         m_pend;
   logic [7:0] exp_q[$];

   pwm_ramp_ctrl #(.W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_period (cmd_period),
      .cmd_duty   (cmd_duty),
      .cmd_step   (cmd_step),
      .period     (period),
      .duty_cycle (duty_cycle),
      .busy       (busy),
`ifdef PWM_RAMP_ABORT_EN
      .abort      (abort),
      .aborted    (aborted),
`endif
      .done       (done)
   );

`ifndef PWM_RAMP_ABORT_EN
   assign aborted = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Expected duty after each boundary of a ramp, pushed when the command is accepted.
   task automatic push_ramp(input int d0, input int tgt, input int stp);
      int d;
      d = d0;
      do begin
         if (stp == 0)        d = tgt;
         else if (d < tgt)    d = (d + stp > tgt) ? tgt : d + stp;
         else if (d > tgt)    d = (d - tgt <= stp) ? tgt : d - stp;
         exp_q.push_back(8'(d));
      end while (d != tgt);
   endtask

   // Model: advances at each clock edge from pre-edge inputs, resets asynchronously.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            gcnt = 0; gper = 0; tper = 0; mduty = 8'd0;
            m_ramp = 1'b0; m_done = 1'b0; m_abd = 1'b0; m_pend = 1'b0;
            exp_q.delete();
         end else begin
            int nxt;
            nxt = gcnt + 1;
            if (nxt >= gper) nxt = 0;
            m_done = 1'b0;
            m_abd  = 1'b0;
            if (m_ramp && nxt == 0) begin
               if (m_pend || abort) begin
                  mduty = 8'd0; m_abd = 1'b1; m_ramp = 1'b0;
                  exp_q.delete();
               end else begin
                  gper  = tper;
                  mduty = exp_q.pop_front();
                  if (exp_q.size() == 0) begin
                     m_ramp = 1'b0; m_done = 1'b1;
                  end
               end
               m_pend = 1'b0;
            end else if (m_ramp) begin
               m_pend = m_pend || abort;
            end else if (cmd_valid) begin
               tper = int'(cmd_period);
               push_ramp(int'(mduty), int'(cmd_duty), int'(cmd_step));
               m_ramp = 1'b1;
               m_pend = 1'b0;
            end
            gcnt = nxt;
         end
      end
   end

   // Per-cycle comparison on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check_eq("mcnt",       32'(dut.mcnt_r), 32'(gcnt));
            check_eq("period",     32'(period),     32'(gper));
            check_eq("duty",       32'(duty_cycle), 32'(mduty));
            check_eq("busy",       32'(busy),       32'(m_ramp));
            check_eq("cmd_ready",  32'(cmd_ready),  32'(!m_ramp));
            check_eq("done",       32'(done),       32'(m_done));
            check_eq("aborted",    32'(aborted),    32'(m_abd));
         end
      end
   end

   task automatic send(input int p, input int d, input int s);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_period = 8'(p);
      cmd_duty   = 8'(d);
      cmd_step   = 8'(s);
      @(negedge clk);
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_ramp && n < budget);
      check_eq("idle_timeout", 32'(m_ramp), 32'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
      cmd_period = 8'd0; cmd_duty = 8'd0; cmd_step = 8'd0;
      #23 rst_n = 1'b1;
      chk_on = 1'b1;
      repeat (20) @(negedge clk);

      send(10, 40, 10);   wait_idle(200);
      send(10, 5, 15);    wait_idle(200);
      send(255, 200, 0);  wait_idle(600);
      send(255, 200, 0);  wait_idle(600);
      send(10, 250, 0);   wait_idle(600);
      send(1, 3, 1);      wait_idle(2000);

      // valid held through a ramp: second field set must wait for the done cycle
      @(negedge clk);
      cmd_valid = 1'b1; cmd_period = 8'd20; cmd_duty = 8'd100; cmd_step = 8'd30;
      @(negedge clk);
      cmd_period = 8'd50; cmd_duty = 8'd60; cmd_step = 8'd7;
      n = 0;
      while (!m_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("hold_done_seen", 32'(m_done), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("b2b_busy", 32'(busy), 32'd1);
      wait_idle(2000);

`ifdef PWM_RAMP_ABORT_EN
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      send(40, 0, 0);     wait_idle(200);
      send(40, 100, 10);
      n = 0;
      while (mduty != 8'd20 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("abort_reach20", 32'(mduty), 32'd20);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle(200);
`endif

      // asynchronous reset in the middle of a ramp
      send(30, 200, 5);
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_period",    32'(period),     32'd0);
      check_eq("rst_duty",      32'(duty_cycle), 32'd0);
      check_eq("rst_busy",      32'(busy),       32'd0);
      check_eq("rst_done",      32'(done),       32'd0);
      check_eq("rst_cmd_ready", 32'(cmd_ready),  32'd1);
      check_eq("rst_aborted",   32'(aborted),    32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send(3, 9, 4);      wait_idle(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Command-driven controller that owns the `period` and `duty_cycle` configuration inputs of the team's 8-bit PWM generator. It accepts a ramp command via a valid/ready handshake and steps the duty cycle toward the target once per PWM period. It changes configuration only on PWM period boundaries, so the generator never sees a mid-period update. It sits between the control-register block and the PWM generator, one instance per PWM channel.

## Interface
Parameters:
- `W`, 8, width of period/duty/step; must match the generator (8).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_period`  in  W  new PWM period.
- `cmd_duty`  in  W  target duty cycle.
- `cmd_step`  in  W  duty change per PWM period; 0 means jump directly to target.
- `period`  out  W  registered; drives generator `period`.
- `duty_cycle`  out  W  registered; drives generator `duty_cycle`.
- `busy`  out  1  registered; high while a command is in progress.
- `done`  out  1  registered; one-cycle pulse when target is reached.
- `abort`  in  1  present only with `PWM_RAMP_ABORT_EN`.
- `aborted`  out  1  present only with `PWM_RAMP_ABORT_EN`; one-cycle pulse.

## Operation
- Mirror counter `mcnt` (W bits) tracks the generator counter exactly:
  - `nxt = mcnt + 1`; if `nxt >= period`, `nxt = 0`.
  - `mcnt <= nxt` every cycle.
  - Reset value 0.
- Boundary: `bnd = (nxt == 0)`. With `period` 0 or 1, `bnd` is high every cycle.
- The controller latches command fields on accept (`cmd_valid && cmd_ready`) into `tgt_period`, `tgt_duty`, `step`.
- States:
  - IDLE: `cmd_ready=1`. On accept -> RAMP, and `busy<=1`.
  - RAMP: on each `bnd` edge, `period<=tgt_period` and `duty_cycle<=f(duty_cycle)`. If the new duty equals `tgt_duty`: `done<=1`, `busy<=0`, -> IDLE.
- Step function f, computed at W+1 bits with no wrap:
  - If `step==0`: result is `tgt_duty`.
  - Up (`duty < tgt`): `min(duty+step, tgt)`.
  - Down (`duty > tgt`): if `duty - tgt <= step`, result is `tgt`; else `duty - step`.
  - Equal: result is `tgt`. Completes on the first boundary.
- `tgt_duty > tgt_period` is legal and means constant high. No clamping.
- When not on a boundary edge, `period`, `duty_cycle` and `mcnt` behave identically in every state.
- `cmd_valid` while busy is ignored. It is not queued, and the command fields are not sampled.

## Timing
- Reset values: `period=0`, `duty_cycle=0`, `busy=0`, `done=0`, `aborted=0`, state IDLE, `cmd_ready=1`, `mcnt=0`.
- Reset mid-ramp returns all of the above on assertion, asynchronously. No boundary wait.
- Accept edge T: `busy=1` and `cmd_ready=0` from T+1.
- The first update occurs at the first `bnd` edge at or after T+1. `mcnt` keeps using the old `period` until that edge.
- The generator sees new values from the cycle after the update edge.
- `done` is high for exactly the cycle after the final update edge. `cmd_ready` returns high in that same cycle, so a back-to-back command can be accepted while `done=1`.
- Ramp length is `ceil(|tgt-duty0|/step)` boundaries, minimum 1.

## Configuration
- `PWM_RAMP_ABORT_EN` defined:
  - Adds the `abort` and `aborted` ports.
  - `abort` is sampled in RAMP. A sampled `abort` is held pending internally until the next `bnd` edge.
  - At that `bnd` edge: `duty_cycle<=0`, `period` is unchanged, `aborted<=1` for one cycle, `done` stays 0, `busy<=0`, -> IDLE.
  - If `abort` and completion coincide on the same boundary, abort wins.
  - `abort` in IDLE is ignored.
- Not defined: no ports and no logic for abort. A ramp always runs to `done`.

## Test plan
- Reset then idle 20 cycles -> `period=0`, `duty_cycle=0`, `cmd_ready=1`, `busy=0`, `done` never pulses.
- Command period=10, duty=40, step=10 from duty 0 -> updates only on `bnd` edges; duty goes 10, 20, 30, 40 on 4 consecutive boundaries; `done` on the 4th; `period=10` from the 1st.
- From duty 40, command duty=5, step=15 -> duty goes 25, 10, 5 (clamped final step); `done` after 3 boundaries. Check that `mcnt` matches a generator model every cycle.
- `cmd_step=0`, duty 5->200, period=255 -> a single boundary sets duty 200, then `done`. The same test with `cmd_duty` equal to the current duty also completes in 1 boundary.
- `cmd_valid` held high through a ramp with different fields -> those fields are ignored. The next command is accepted in the `done` cycle.
- With `PWM_RAMP_ABORT_EN`, pulse `abort` mid-ramp at duty 20 -> at the next boundary duty becomes 0, `aborted` pulses, and `done` stays 0. Also assert `rst_n` mid-ramp -> all outputs reset immediately.
